// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator serializing one access into byte transfers on a memory port.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject addresses not aligned to the access size.
module load_store_unit #(
   parameter int unsigned ADDR_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            Funct3,
   input  logic [ADDR_WIDTH-1:0] Mem_Addr,
   input  logic [63:0]           Write_Data,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [63:0]           Read_Data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [7:0]            mem_rdata
);

   localparam int unsigned DW = 64;
   localparam int unsigned BW = 8;
   localparam int unsigned KW = 3;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [KW-1:0]         r_k,         w_k_nxt;
   logic [2:0]            r_funct3,    w_funct3_nxt;
   logic                  r_is_load,   w_is_load_nxt;
   logic [DW-1:0]         r_wdata,     w_wdata_nxt;
   logic [DW-1:0]         r_shift,     w_shift_nxt;
   logic                  r_busy,      w_busy_nxt;
   logic                  r_done,      w_done_nxt;
   logic                  r_err,       w_err_nxt;
   logic [DW-1:0]         r_read_data, w_read_data_nxt;
   logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
   logic [BW-1:0]         r_mem_wdata, w_mem_wdata_nxt;
   logic                  r_mem_we,    w_mem_we_nxt;
   logic                  r_mem_re,    w_mem_re_nxt;
   logic                  w_misalign;
   logic                  w_illegal;
   logic [KW-1:0]         w_last_k;

   function automatic logic [KW-1:0] last_k(input logic [1:0] size);
      case (size)
         2'b00:   return KW'(0);
         2'b01:   return KW'(1);
         2'b10:   return KW'(3);
         default: return KW'(7);
      endcase
   endfunction

   // Sign- or zero-extend the assembled bytes according to the latched size code.
   function automatic logic [DW-1:0] extend(input logic [DW-1:0] d, input logic [2:0] f3);
      logic s;
      s = ~f3[2];
      case (f3[1:0])
         2'b00:   return {{56{s & d[7]}},  d[7:0]};
         2'b01:   return {{48{s & d[15]}}, d[15:0]};
         2'b10:   return {{32{s & d[31]}}, d[31:0]};
         default: return d;
      endcase
   endfunction

`ifdef LSU_MISALIGN_CHECK_EN
   assign w_misalign = (Mem_Addr[2:0] & last_k(Funct3[1:0])) != 3'b000;
`else
   assign w_misalign = 1'b0;
`endif

   assign w_illegal = (Funct3 == 3'b111) || (MemRead == MemWrite) ||
                      ((Funct3[2:1] == 2'b11) && MemWrite) || w_misalign;
   assign w_last_k  = last_k(r_funct3[1:0]);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_nxt = w_illegal ? S_DONE : S_ACCESS;
         S_ACCESS: if (r_k == w_last_k) w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Next values for the datapath and every registered port.
   always_comb begin
      w_busy_nxt      = 1'b0;
      w_done_nxt      = 1'b0;
      w_err_nxt       = 1'b0;
      w_mem_we_nxt    = 1'b0;
      w_mem_re_nxt    = 1'b0;
      w_mem_addr_nxt  = '0;
      w_mem_wdata_nxt = '0;
      w_read_data_nxt = r_read_data;
      w_k_nxt         = r_k;
      w_funct3_nxt    = r_funct3;
      w_is_load_nxt   = r_is_load;
      w_wdata_nxt     = r_wdata;
      w_shift_nxt     = r_shift;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_busy_nxt = 1'b1;
               if (w_illegal) begin
                  w_done_nxt = 1'b1;
                  w_err_nxt  = 1'b1;
               end else begin
                  w_k_nxt         = '0;
                  w_funct3_nxt    = Funct3;
                  w_is_load_nxt   = MemRead;
                  w_wdata_nxt     = Write_Data;
                  w_shift_nxt     = '0;
                  w_mem_addr_nxt  = Mem_Addr;
                  w_mem_we_nxt    = MemWrite;
                  w_mem_re_nxt    = MemRead;
                  w_mem_wdata_nxt = MemWrite ? Write_Data[7:0] : 8'h00;
               end
            end
         end
         S_ACCESS: begin
            w_busy_nxt = 1'b1;
            if (r_is_load) w_shift_nxt[{r_k, 3'b000} +: BW] = mem_rdata;
            if (r_k == w_last_k) begin
               w_done_nxt = 1'b1;
               if (r_is_load) w_read_data_nxt = extend(w_shift_nxt, r_funct3);
            end else begin
               w_k_nxt         = r_k + KW'(1);
               w_wdata_nxt     = r_wdata >> BW;
               w_mem_addr_nxt  = r_mem_addr + ADDR_WIDTH'(1);
               w_mem_we_nxt    = ~r_is_load;
               w_mem_re_nxt    = r_is_load;
               w_mem_wdata_nxt = r_is_load ? 8'h00 : r_wdata[15:8];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_k         <= '0;
         r_funct3    <= '0;
         r_is_load   <= 1'b0;
         r_wdata     <= '0;
         r_shift     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_read_data <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_mem_re    <= 1'b0;
      end else begin
         r_k         <= w_k_nxt;
         r_funct3    <= w_funct3_nxt;
         r_is_load   <= w_is_load_nxt;
         r_wdata     <= w_wdata_nxt;
         r_shift     <= w_shift_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_err       <= w_err_nxt;
         r_read_data <= w_read_data_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_re    <= w_mem_re_nxt;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign Read_Data = r_read_data;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_we    = r_mem_we;
   assign mem_re    = r_mem_re;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 64-byte memory model preset to mem[i]=i.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  Funct3;
   logic [63:0] Mem_Addr;
   logic [63:0] Write_Data;
   logic        busy;
   logic        done;
   logic        err;
   logic [63:0] Read_Data;
   logic [63:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;

   logic [7:0]  mem [0:63];
   logic        mem_init;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] hold;

   load_store_unit #(.ADDR_WIDTH(64)) dut (
      .clk(clk), .reset(reset), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
      .Funct3(Funct3), .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .busy(busy),
      .done(done), .err(err), .Read_Data(Read_Data), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[5:0]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
      end else if (mem_we) begin
         mem[mem_addr[5:0]] <= mem_wdata;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd);
      MemRead = rd; MemWrite = wr; Funct3 = f3; Mem_Addr = addr; Write_Data = wd;
   endtask

   // Issue one request and check every cycle up to and after its done pulse.
   task automatic run_req(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wd,
                          input int n, input logic exp_err, input logic [63:0] exp_rd);
      set_req(rd, wr, f3, addr, wd);
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int k = 0; k < n; k++) begin
         check({tag, " re"},   64'(mem_re), 64'(rd));
         check({tag, " we"},   64'(mem_we), 64'(wr));
         check({tag, " addr"}, mem_addr, addr + 64'(k));
         if (wr) check({tag, " wdata"}, 64'(mem_wdata), 64'(wd[8*k +: 8]));
         check({tag, " busy"}, 64'(busy), 64'd1);
         check({tag, " early done"}, 64'(done), 64'd0);
         tick;
      end
      check({tag, " done"},  64'(done), 64'd1);
      check({tag, " err"},   64'(err), 64'(exp_err));
      check({tag, " rdata"}, Read_Data, exp_rd);
      check({tag, " port idle"}, {62'd0, mem_re, mem_we}, 64'd0);
      tick;
      check({tag, " done drop"}, {62'd0, done, busy}, 64'd0);
   endtask

   initial begin
      int ndone;
      int dcyc;
      reset = 1'b1; mem_init = 1'b1; start = 1'b0;
      set_req(1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
      repeat (3) tick;
      check("rst ctl", {61'd0, busy, done, err}, 64'd0);
      check("rst port", {62'd0, mem_we, mem_re}, 64'd0);
      check("rst rdata", Read_Data, 64'd0);
      check("rst addr", mem_addr, 64'd0);
      check("rst wdata", 64'(mem_wdata), 64'd0);
      mem_init = 1'b0;

      // Reset wins over a simultaneous start.
      set_req(1'b1, 1'b0, 3'b011, 64'd8, 64'd0);
      start = 1'b1;
      tick;
      check("rst+start", {62'd0, busy, mem_re}, 64'd0);
      reset = 1'b0; start = 1'b0;
      tick;
      check("post rst idle", 64'(busy), 64'd0);

      run_req("ld8", 1'b1, 1'b0, 3'b011, 64'd8, 64'd0, 8, 1'b0, 64'h0F0E0D0C0B0A0908);
      run_req("sd16", 1'b0, 1'b1, 3'b011, 64'd16, 64'h8877665544332211, 8, 1'b0,
              64'h0F0E0D0C0B0A0908);
      for (int i = 0; i < 8; i++) check("sd mem", 64'(mem[16+i]), 64'((i + 1) * 8'h11));
      run_req("lb23",  1'b1, 1'b0, 3'b000, 64'd23, 64'd0, 1, 1'b0, 64'hFFFFFFFFFFFFFF88);
      run_req("lbu23", 1'b1, 1'b0, 3'b100, 64'd23, 64'd0, 1, 1'b0, 64'h0000000000000088);
      run_req("lw20",  1'b1, 1'b0, 3'b010, 64'd20, 64'd0, 4, 1'b0, 64'hFFFFFFFF88776655);
      run_req("lwu20", 1'b1, 1'b0, 3'b110, 64'd20, 64'd0, 4, 1'b0, 64'h0000000088776655);
      run_req("lh22",  1'b1, 1'b0, 3'b001, 64'd22, 64'd0, 2, 1'b0, 64'hFFFFFFFFFFFF8877);
      run_req("lhu22", 1'b1, 1'b0, 3'b101, 64'd22, 64'd0, 2, 1'b0, 64'h0000000000008877);
      hold = 64'h0000000000008877;
`ifdef LSU_MISALIGN_CHECK_EN
      run_req("lw2 misalign", 1'b1, 1'b0, 3'b010, 64'd2, 64'd0, 0, 1'b1, hold);
      run_req("lh wrap misalign", 1'b1, 1'b0, 3'b001, 64'hFFFFFFFFFFFFFFFF, 64'd0, 0, 1'b1, hold);
`else
      run_req("lw2", 1'b1, 1'b0, 3'b010, 64'd2, 64'd0, 4, 1'b0, 64'h0000000005040302);
      run_req("lh wrap", 1'b1, 1'b0, 3'b001, 64'hFFFFFFFFFFFFFFFF, 64'd0, 2, 1'b0,
              64'h000000000000003F);
      hold = 64'h000000000000003F;
`endif
      run_req("f3 111",  1'b1, 1'b0, 3'b111, 64'd8, 64'd0, 0, 1'b1, hold);
      run_req("rd&wr",   1'b1, 1'b1, 3'b011, 64'd8, 64'd0, 0, 1'b1, hold);
      run_req("no dir",  1'b0, 1'b0, 3'b010, 64'd8, 64'd0, 0, 1'b1, hold);
      run_req("sw uns",  1'b0, 1'b1, 3'b110, 64'd8, 64'd0, 0, 1'b1, hold);
      check("sw uns mem", 64'(mem[8]), 64'h08);

      // A start pulse during an access is dropped, not queued.
      set_req(1'b1, 1'b0, 3'b011, 64'd8, 64'd0);
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      set_req(1'b1, 1'b0, 3'b000, 64'd0, 64'd0);
      start = 1'b1;
      tick;
      start = 1'b0;
      ndone = 0; dcyc = 0;
      for (int c = 4; c <= 14; c++) begin
         if (done) begin ndone++; dcyc = c; end
         tick;
      end
      check("stray ndone", 64'(ndone), 64'd1);
      check("stray dcyc", 64'(dcyc), 64'd9);
      check("stray rdata", Read_Data, 64'h0F0E0D0C0B0A0908);

      // Reset raised at the end of cycle 3 of a store aborts it.
      set_req(1'b0, 1'b1, 3'b011, 64'd16, 64'hF8F7F6F5F4F3F2F1);
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      check("abort c3 we", {63'd0, mem_we}, 64'd1);
      check("abort c3 addr", mem_addr, 64'd18);
      reset = 1'b1;
      tick;
      check("abort ctl", {61'd0, busy, done, err}, 64'd0);
      check("abort port", {62'd0, mem_we, mem_re}, 64'd0);
      check("abort addr", mem_addr, 64'd0);
      check("abort wdata", 64'(mem_wdata), 64'd0);
      check("abort rdata", Read_Data, 64'd0);
      reset = 1'b0;
      ndone = 0;
      for (int c = 0; c < 10; c++) begin
         if (done || mem_we) ndone++;
         tick;
      end
      check("abort quiet", 64'(ndone), 64'd0);
      check("abort m16", 64'(mem[16]), 64'hF1);
      check("abort m17", 64'(mem[17]), 64'hF2);
      check("abort m18", 64'(mem[18]), 64'hF3);
      check("abort m19", 64'(mem[19]), 64'h44);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
